// File: rtl/decode_stage_if.sv
// Decode stage bus: fetch-side handshake, execute-side held instruction,
// register-file read addresses, writeback notification and flush.
interface decode_stage_if;
  // fetch side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;

  // register-file read addresses for the held instruction
  logic [3:0]  read_loc_1;
  logic [3:0]  read_loc_2;

  // execute side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [3:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;

  // writeback completion
  logic        wb_valid;
  logic [3:0]  wb_loc;

  // environment view: drives fetch, execute handshake and writeback
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_loc,
    input  in_ready, read_loc_1, read_loc_2,
    input  out_valid, out_pc, out_opcode, out_funct3, out_funct7b5,
    input  out_rd, out_imm, out_illegal
  );

  // decode stage view
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_loc,
    output in_ready, read_loc_1, read_loc_2,
    output out_valid, out_pc, out_opcode, out_funct3, out_funct7b5,
    output out_rd, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32E-style decode stage: legality check, immediate generation, a
// per-register busy scoreboard for hazard stalls, and a one-entry output
// register toward execute with valid/ready handshake and flush.
module decode_stage #(
  parameter int unsigned SCOREBOARD_EN = 1
) (
  input  logic          clock,
  input  logic          reset,
  decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // decode wires
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  imm_fmt_e    w_fmt;
  logic        w_op_legal;
  logic        w_raw_rd;
  logic        w_raw_rs1;
  logic        w_raw_rs2;
  logic        w_illegal;
  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic [31:0] w_imm;

  // scoreboard / handshake wires
  logic [15:0] w_clr;
  logic [15:0] w_eff_busy;
  logic [15:0] w_flush_clr;
  logic [15:0] w_set;
  logic [15:0] w_busy_next;
  logic        w_stall;
  logic        w_in_ready;
  logic        w_accept;

  // registers
  logic [15:0] r_busy;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [6:0]  r_out_opcode;
  logic [2:0]  r_out_funct3;
  logic        r_out_funct7b5;
  logic [3:0]  r_out_rd;
  logic [31:0] r_out_imm;
  logic        r_out_illegal;
  logic [3:0]  r_read_loc_1;
  logic [3:0]  r_read_loc_2;

  assign w_instr  = bus.in_instr;
  assign w_opcode = w_instr[6:0];

  // Classify the opcode: immediate format and which register fields it names.
  always_comb begin
    w_fmt      = FMT_NONE;
    w_op_legal = 1'b0;
    w_raw_rd   = 1'b0;
    w_raw_rs1  = 1'b0;
    w_raw_rs2  = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_op_legal = 1'b1;
        w_fmt      = FMT_U;
        w_raw_rd   = 1'b1;
      end
      OPC_JAL: begin
        w_op_legal = 1'b1;
        w_fmt      = FMT_J;
        w_raw_rd   = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_op_legal = 1'b1;
        w_fmt      = FMT_I;
        w_raw_rd   = 1'b1;
        w_raw_rs1  = 1'b1;
      end
      OPC_BRANCH: begin
        w_op_legal = 1'b1;
        w_fmt      = FMT_B;
        w_raw_rs1  = 1'b1;
        w_raw_rs2  = 1'b1;
      end
      OPC_STORE: begin
        w_op_legal = 1'b1;
        w_fmt      = FMT_S;
        w_raw_rs1  = 1'b1;
        w_raw_rs2  = 1'b1;
      end
      OPC_OP: begin
        w_op_legal = 1'b1;
        w_raw_rd   = 1'b1;
        w_raw_rs1  = 1'b1;
        w_raw_rs2  = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        w_op_legal = 1'b1;
      end
      default: begin
        w_op_legal = 1'b0;
      end
    endcase
  end

  // Only 16 architectural registers exist: bit 4 of any used field is illegal.
  assign w_illegal = !w_op_legal || (w_instr[1:0] != 2'b11) ||
                     (w_raw_rd  && w_instr[11]) ||
                     (w_raw_rs1 && w_instr[19]) ||
                     (w_raw_rs2 && w_instr[24]);

  assign w_use_rd  = w_raw_rd  && !w_illegal;
  assign w_use_rs1 = w_raw_rs1 && !w_illegal;
  assign w_use_rs2 = w_raw_rs2 && !w_illegal;

  // Unused fields read as 0 so they never hit the scoreboard or the flush clear.
  assign w_rd  = w_use_rd  ? w_instr[10:7]  : '0;
  assign w_rs1 = w_use_rs1 ? w_instr[18:15] : '0;
  assign w_rs2 = w_use_rs2 ? w_instr[23:20] : '0;

  // Sign-extended immediate for the decoded format; zero when illegal.
  always_comb begin
    w_imm = '0;
    if (!w_illegal) begin
      case (w_fmt)
        FMT_I:   w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        FMT_S:   w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        FMT_B:   w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                          w_instr[30:25], w_instr[11:8], 1'b0};
        FMT_U:   w_imm = {w_instr[31:12], 12'h000};
        FMT_J:   w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                          w_instr[20], w_instr[30:21], 1'b0};
        default: w_imm = '0;
      endcase
    end
  end

  // A writeback completing this cycle already unblocks a dependent instruction.
  assign w_clr      = bus.wb_valid ? (16'd1 << bus.wb_loc) : '0;
  assign w_eff_busy = r_busy & ~w_clr;

  assign w_stall = bus.in_valid &&
                   ((w_use_rs1 && w_eff_busy[w_rs1]) ||
                    (w_use_rs2 && w_eff_busy[w_rs2]) ||
                    (w_use_rd  && w_eff_busy[w_rd]));

  assign w_in_ready = reset && !bus.flush && !w_stall &&
                      (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // A flushed instruction that execute never took will not write back.
  assign w_flush_clr = (bus.flush && r_out_valid && !bus.out_ready && (r_out_rd != '0)) ?
                       (16'd1 << r_out_rd) : '0;
  assign w_set       = (w_accept && w_use_rd && (w_rd != '0)) ? (16'd1 << w_rd) : '0;

  // Set is applied after both clears so a same-location set wins.
  assign w_busy_next = ((r_busy & ~w_clr & ~w_flush_clr) | w_set) & 16'hFFFE;

  generate
    if (SCOREBOARD_EN != 0) begin : g_scoreboard
      // Busy mask tracks destinations still awaiting writeback.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_busy <= '0;
        end else begin
          r_busy <= w_busy_next;
        end
      end
    end else begin : g_no_scoreboard
      assign r_busy = '0;
    end
  endgenerate

  // Output register: load on accept, drop valid on flush or consume.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_funct7b5 <= 1'b0;
      r_out_rd       <= '0;
      r_out_imm      <= '0;
      r_out_illegal  <= 1'b0;
      r_read_loc_1   <= '0;
      r_read_loc_2   <= '0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= bus.in_pc;
      r_out_opcode   <= w_opcode;
      r_out_funct3   <= w_instr[14:12];
      r_out_funct7b5 <= w_instr[30];
      r_out_rd       <= w_rd;
      r_out_imm      <= w_imm;
      r_out_illegal  <= w_illegal;
      r_read_loc_1   <= w_rs1;
      r_read_loc_2   <= w_rs2;
    end else if (bus.flush || bus.out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_opcode   = r_out_opcode;
  assign bus.out_funct3   = r_out_funct3;
  assign bus.out_funct7b5 = r_out_funct7b5;
  assign bus.out_rd       = r_out_rd;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_illegal  = r_out_illegal;
  assign bus.read_loc_1   = r_read_loc_1;
  assign bus.read_loc_2   = r_read_loc_2;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_decode_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;

  decode_stage_if bus ();

  decode_stage #(.SCOREBOARD_EN(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        legal;
    logic        urd;
    logic        urs1;
    logic        urs2;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } dec_t;

  // reference model state
  logic [15:0] m_busy;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7;
  logic [3:0]  m_rd;
  logic [31:0] m_imm;
  logic        m_ill;
  logic [3:0]  m_rl1;
  logic [3:0]  m_rl2;

  // Architectural decode written from the instruction-set rules.
  function automatic dec_t decode_ref(input logic [31:0] ins);
    dec_t d;
    byte  k;
    int   v;
    d.legal = 1'b0; d.urd = 1'b0; d.urs1 = 1'b0; d.urs2 = 1'b0;
    k = "X";
    case (ins[6:0])
      7'b0110111, 7'b0010111:             begin k = "U"; d.urd = 1; end
      7'b1101111:                         begin k = "J"; d.urd = 1; end
      7'b1100111, 7'b0000011, 7'b0010011: begin k = "I"; d.urd = 1; d.urs1 = 1; end
      7'b1100011:                         begin k = "B"; d.urs1 = 1; d.urs2 = 1; end
      7'b0100011:                         begin k = "S"; d.urs1 = 1; d.urs2 = 1; end
      7'b0110011:                         begin k = "N"; d.urd = 1; d.urs1 = 1; d.urs2 = 1; end
      7'b0001111, 7'b1110011:             k = "N";
      default:                            k = "X";
    endcase
    d.legal = (k != "X") && (ins[1:0] == 2'b11) &&
              !(d.urd && ins[11]) && !(d.urs1 && ins[19]) && !(d.urs2 && ins[24]);
    if (!d.legal) begin
      d.urd = 0; d.urs1 = 0; d.urs2 = 0; k = "N";
    end
    case (k)
      "I": begin v = int'(ins[31:20]); if (v >= 2048) v -= 4096; end
      "S": begin v = int'(ins[31:25]) * 32 + int'(ins[11:7]); if (v >= 2048) v -= 4096; end
      "B": v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
               int'(ins[11:8]) * 2;
      "U": v = int'(ins[31:12]) * 4096;
      "J": v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
               int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    d.imm = v;
    d.rd  = d.urd  ? ins[10:7]  : 4'd0;
    d.rs1 = d.urs1 ? ins[18:15] : 4'd0;
    d.rs2 = d.urs2 ? ins[23:20] : 4'd0;
    return d;
  endfunction

  function automatic logic [15:0] eff_busy();
    logic [15:0] c;
    c = 16'h0;
    if (bus.wb_valid) c[bus.wb_loc] = 1'b1;
    return m_busy & ~c;
  endfunction

  function automatic logic exp_ready();
    dec_t        d;
    logic [15:0] e;
    logic        st;
    d  = decode_ref(bus.in_instr);
    e  = eff_busy();
    st = bus.in_valid && ((d.urs1 && e[d.rs1]) || (d.urs2 && e[d.rs2]) ||
                          (d.urd && d.rd != 0 && e[d.rd]));
    return reset && !bus.flush && !st && (!m_valid || bus.out_ready);
  endfunction

  task automatic model_reset();
    m_busy = 16'h0; m_valid = 0; m_pc = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
    m_rd = 0; m_imm = 0; m_ill = 0; m_rl1 = 0; m_rl2 = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    dec_t        d;
    logic [15:0] nb;
    logic        acc;
    if (!reset) begin
      model_reset();
      return;
    end
    d   = decode_ref(bus.in_instr);
    acc = bus.in_valid && exp_ready();
    nb  = eff_busy();
    if (bus.flush && m_valid && !bus.out_ready && m_rd != 0) nb[m_rd] = 1'b0;
    if (acc && d.urd && d.rd != 0) nb[d.rd] = 1'b1;
    if (acc) begin
      m_valid = 1;
      m_pc    = bus.in_pc;
      m_op    = bus.in_instr[6:0];
      m_f3    = bus.in_instr[14:12];
      m_f7    = bus.in_instr[30];
      m_rd    = d.rd;
      m_imm   = d.imm;
      m_ill   = !d.legal;
      m_rl1   = d.rs1;
      m_rl2   = d.rs2;
    end else if (bus.flush || bus.out_ready) begin
      m_valid = 0;
    end
    m_busy = nb;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_valid",    32'(bus.out_valid),    32'(m_valid));
    chk("out_pc",       bus.out_pc,            m_pc);
    chk("out_opcode",   32'(bus.out_opcode),   32'(m_op));
    chk("out_funct3",   32'(bus.out_funct3),   32'(m_f3));
    chk("out_funct7b5", 32'(bus.out_funct7b5), 32'(m_f7));
    chk("out_rd",       32'(bus.out_rd),       32'(m_rd));
    chk("out_imm",      bus.out_imm,           m_imm);
    chk("out_illegal",  32'(bus.out_illegal),  32'(m_ill));
    chk("read_loc_1",   32'(bus.read_loc_1),   32'(m_rl1));
    chk("read_loc_2",   32'(bus.read_loc_2),   32'(m_rl2));
    chk("busy",         32'(dut.r_busy),       32'(m_busy));
    chk("in_ready",     32'(bus.in_ready),     32'(exp_ready()));
  endtask

  // Inputs change at the negedge; check, then let one posedge happen.
  task automatic step();
    #1;
    compare_all();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  function automatic logic [6:0] pick_op(input int unsigned idx);
    case (idx)
      0: return 7'b0110111;  1: return 7'b0010111;  2: return 7'b1101111;
      3: return 7'b1100111;  4: return 7'b1100011;  5: return 7'b0000011;
      6: return 7'b0100011;  7: return 7'b0010011;  8: return 7'b0110011;
      9: return 7'b0001111; 10: return 7'b1110011;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = pick_op($urandom_range(0, 11));
    ins[11:7]  = pick_reg();
    ins[19:15] = pick_reg();
    ins[24:20] = pick_reg();
    return ins;
  endfunction

  initial begin
    bus.in_valid  = 0;
    bus.in_instr  = 0;
    bus.in_pc     = 0;
    bus.flush     = 0;
    bus.out_ready = 0;
    bus.wb_valid  = 0;
    bus.wb_loc    = 0;
    model_reset();

    // reset held low
    #2;
    compare_all();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    reset = 1'b1;

    // first cycle after release
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // addi x1,x0,5
    bus.in_valid = 1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h100; bus.out_ready = 1;
    step();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_imm",   bus.out_imm, 32'd5);
    chk("addi_rd",    32'(bus.out_rd), 32'd1);
    chk("addi_rl1",   32'(bus.read_loc_1), 32'd0);
    chk("addi_busy1", 32'(dut.r_busy[1]), 32'd1);

    // add x2,x1,x1 stalls until x1 writes back
    bus.in_instr = 32'h00108133; bus.in_pc = 32'h104;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("raw_stall", 32'(bus.in_ready), 32'd0);
    end
    bus.wb_valid = 1; bus.wb_loc = 4'd1;
    #1;
    chk("wb_bypass", 32'(bus.in_ready), 32'd1);
    step();
    bus.wb_valid = 0;
    chk("add_rd",   32'(bus.out_rd), 32'd2);
    chk("add_busy", 32'(dut.r_busy), 32'h0004);

    // rd = x16 is illegal, never stalls, leaves busy alone
    bus.in_instr = 32'h00000813; bus.in_pc = 32'h108;
    step();
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_rd",   32'(bus.out_rd), 32'd0);
    chk("ill_busy", 32'(dut.r_busy), 32'h0004);

    // addi x3,x0,7 then hold it with out_ready low
    bus.in_instr = 32'h00700193; bus.in_pc = 32'h10C;
    step();
    bus.out_ready = 0; bus.in_instr = 32'h00000013; bus.in_pc = 32'h110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_imm",   bus.out_imm, 32'd7);
      chk("hold_pc",    bus.out_pc, 32'h10C);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_busy",  32'(dut.r_busy), 32'h0004);

    // beq x0,x0,-4
    bus.out_ready = 1; bus.in_instr = 32'hFE000EE3; bus.in_pc = 32'h200;
    step();
    chk("b_imm", bus.out_imm, 32'hFFFFFFFC);

    // asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy",  32'(dut.r_busy), 32'd0);
    chk("arst_imm",   bus.out_imm, 32'd0);
    chk("arst_pc",    bus.out_pc, 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    step();
    reset = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wb_valid  = ($urandom_range(0, 2) == 0);
      bus.wb_loc    = 4'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 19) == 0);
      if (n == 1500) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rand_arst_busy",  32'(dut.r_busy), 32'd0);
        chk("rand_arst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
